vx_csr_requester: RTL and testbench
===================================

# vx_csr_requester

Initiator side of the per-core CSR access interface: accepts one CSR instruction at a time from the SFU issue path and sequences the read, then the optional write, into the CSR data block. Implements the CSRRW/CSRRS/CSRRC read-modify-write semantics, the read-only-address check and the FPU-flags hazard stall. Returns the old CSR value, plus an error flag, to the commit path. Sits between the SFU dispatch and the CSR data block's `read_*`/`write_*` ports.

## Interface
- XLEN, 32: data width (32 or 64)
- NUM_WARPS, 4: warp count
- NW_WIDTH, 2: warp id width, `$clog2(NUM_WARPS)` min 1
- UUID_WIDTH, 1: instruction uuid width
- ADDR_BITS, 12: CSR address width

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  2  0=RW, 1=RS, 2=RC, 3=reserved (treated as RS)
- req_addr  in  ADDR_BITS  CSR address
- req_wid  in  NW_WIDTH  warp id
- req_uuid  in  UUID_WIDTH  uuid
- req_src  in  XLEN  rs1 value or zero-extended uimm
- req_src_zero  in  1  rs1==x0 / uimm==0
- req_rd_zero  in  1  rd==x0
- fpu_pending  in  NUM_WARPS  per-warp FPU ops in flight
- csr_read_enable  out  1  read strobe
- csr_read_uuid / csr_read_wid / csr_read_addr  out  UUID_WIDTH / NW_WIDTH / ADDR_BITS  read request fields
- csr_read_data_ro, csr_read_data_rw  in  XLEN  combinational read data, same cycle
- csr_write_enable  out  1  write strobe
- csr_write_uuid / csr_write_wid / csr_write_addr  out  as read  write request fields
- csr_write_data  out  XLEN  new value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  XLEN  old CSR value (0 if read skipped)
- rsp_error  out  1  write to read-only CSR attempted
- rsp_uuid / rsp_wid  out  UUID_WIDTH / NW_WIDTH  echoed

## Operation
- FSM states: IDLE, HOLD, READ, WRITE, RESP. Request fields are registered on acceptance.
- IDLE: req_ready=1. On accept go to HOLD if the address is an FP CSR (0x001–0x003) and fpu_pending[wid]=1; otherwise go to READ.
- HOLD: outputs idle. Re-evaluate fpu_pending[wid] each cycle. Go to READ when it is 0.
- need_write = (op==RW) | ~src_zero.
- need_read = ~(op==RW & rd_zero).
- ro_addr = addr[11:10]==2'b11.
- READ: when need_read, csr_read_enable=1 for exactly one cycle and old_q <= read_data_ro | read_data_rw. Otherwise strobe low and old_q <= 0.
- New value, computed from old_q in WRITE:
  - RW: src
  - RS: old|src
  - RC: old&~src
- Transition from READ:
  - need_write & ~ro_addr: go to WRITE.
  - need_write & ro_addr: set err_q=1, go to RESP.
  - otherwise: go to RESP.
- WRITE: csr_write_enable=1 for exactly one cycle, then go to RESP.
- RESP: rsp_valid=1, with rsp_data=old_q and rsp_error=err_q. These are held stable until rsp_ready. Go to IDLE on rsp_valid&rsp_ready. err_q is cleared on accept.
- Read and write uuid/wid/addr outputs are driven from registered fields. They are 0 when the corresponding strobe is low.

## Timing
- Reset (async assert, sync deassert internally) forces:
  - state to IDLE
  - all strobes, rsp_valid and rsp_error to 0
  - all data and id outputs to 0
  - req_ready to 0 during reset, 1 on the first cycle after release
- Reset mid-transaction drops the transaction. No partial write is issued after reset.
- Latency, with request accepted at edge T:
  - read at cycle T+1
  - write at T+2
  - rsp_valid from T+3
  - without write: rsp_valid from T+2
  - each HOLD cycle adds 1
- One transaction in flight at most. req_ready=0 in every state except IDLE. No acceptance in the same cycle as the RESP handshake; the next accept is 1 cycle after RESP exits.
- rsp_valid held with rsp_ready=0 indefinitely keeps all rsp_* stable. No further CSR strobes are issued while held.
- fpu_pending toggling in IDLE has no effect. Only the registered wid is sampled in HOLD.
- XLEN arithmetic is bitwise only, with no carries. old_q is the full XLEN OR of ro and rw.

## Test plan
- CSRRW mscratch(0x340), src=0xDEADBEEF, rd≠x0, read returns 0x12345678 -> read strobe at T+1, write 0xDEADBEEF at T+2, rsp_data=0x12345678 at T+3, error 0.
- CSRRS 0x340, src_zero=1, old=0xA5 -> read only, no write strobe, rsp_valid at T+2 with 0xA5.
- CSRRC 0x340, src=0x0F, old=0xFF -> write data 0xF0. CSRRW with rd_zero=1 -> no read strobe, rsp_data=0.
- CSRRW mhartid-class 0xF14, src=1 -> no write strobe, rsp_error=1. The following CSRRS 0xF14 with src_zero=1 -> error 0.
- fcsr (0x003), wid=2, fpu_pending[2]=1 for 5 cycles -> HOLD 5 cycles, read strobe on the cycle after the clear. Toggling fpu_pending[1] has no effect.
- reset_n pulsed low during WRITE -> strobe drops immediately, all outputs 0. rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=0.

Source files
------------

// File: rtl/vx_csr_requester.sv
// vx_csr_requester: initiator side of the per-core CSR access interface.
// It takes one CSR instruction from the SFU issue path at a time. For each
// instruction it issues an optional read, then an optional read-modify-write,
// to the CSR data block. It then returns the old CSR value and an error flag
// to the commit path.
module vx_csr_requester #(
    parameter int XLEN       = 32,
    parameter int NUM_WARPS  = 4,
    parameter int NW_WIDTH   = 2,
    parameter int UUID_WIDTH = 1,
    parameter int ADDR_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,

    // instruction request from SFU dispatch
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [NW_WIDTH-1:0]   req_wid,
    input  logic [UUID_WIDTH-1:0] req_uuid,
    input  logic [XLEN-1:0]       req_src,
    input  logic                  req_src_zero,
    input  logic                  req_rd_zero,

    // per-warp FPU ops in flight (FP flag hazard)
    input  logic [NUM_WARPS-1:0]  fpu_pending,

    // CSR data block read port
    output logic                  csr_read_enable,
    output logic [UUID_WIDTH-1:0] csr_read_uuid,
    output logic [NW_WIDTH-1:0]   csr_read_wid,
    output logic [ADDR_BITS-1:0]  csr_read_addr,
    input  logic [XLEN-1:0]       csr_read_data_ro,
    input  logic [XLEN-1:0]       csr_read_data_rw,

    // CSR data block write port
    output logic                  csr_write_enable,
    output logic [UUID_WIDTH-1:0] csr_write_uuid,
    output logic [NW_WIDTH-1:0]   csr_write_wid,
    output logic [ADDR_BITS-1:0]  csr_write_addr,
    output logic [XLEN-1:0]       csr_write_data,

    // response to commit
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  rsp_error,
    output logic [UUID_WIDTH-1:0] rsp_uuid,
    output logic [NW_WIDTH-1:0]   rsp_wid
);

    localparam logic [1:0] OP_RW = 2'd0;
    localparam logic [1:0] OP_RC = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic                    r_rstDone;

    logic [1:0]              r_op;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [NW_WIDTH-1:0]     r_wid;
    logic [UUID_WIDTH-1:0]   r_uuid;
    logic [XLEN-1:0]         r_src;
    logic                    r_srcZero;
    logic                    r_rdZero;
    logic [XLEN-1:0]         r_old;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_reqIsFp;
    logic                    w_fpPendReq;
    logic                    w_fpPendHeld;
    logic                    w_needWrite;
    logic                    w_needRead;
    logic                    w_roAddr;
    logic                    w_readEn;
    logic                    w_writeEn;
    logic                    w_rspFire;
    logic [XLEN-1:0]         w_readData;
    logic [XLEN-1:0]         w_newVal;

    // Requests are accepted only in IDLE. Acceptance also waits one clock
    // after reset release, so it starts on a synchronised edge.
    assign req_ready   = r_rstDone && (r_state == IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_rspFire   = (r_state == RESP) && rsp_ready;

    // The FP CSRs (fflags/frm/fcsr) are the only ones hazarded on in-flight FPU ops.
    assign w_reqIsFp    = (req_addr >= ADDR_BITS'(1)) && (req_addr <= ADDR_BITS'(3));
    assign w_fpPendReq  = fpu_pending[req_wid];
    assign w_fpPendHeld = fpu_pending[r_wid];

    // An instruction decoded from the registered fields.
    assign w_needWrite = (r_op == OP_RW) || !r_srcZero;
    assign w_needRead  = !((r_op == OP_RW) && r_rdZero);
    assign w_roAddr    = (r_addr[ADDR_BITS-1 -: 2] == 2'b11);
    assign w_readData  = csr_read_data_ro | csr_read_data_rw;

    // Tracks the first clock after reset release, so deassertion is synchronised
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rstDone <= 1'b0;
        end else begin
            r_rstDone <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the single-cycle read/write strobes
    always_comb begin
        w_nextState = r_state;
        w_readEn    = 1'b0;
        w_writeEn   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = (w_reqIsFp && w_fpPendReq) ? HOLD : READ;
                end
            end
            HOLD: begin
                if (!w_fpPendHeld) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                w_readEn    = w_needRead;
                w_nextState = (w_needWrite && !w_roAddr) ? WRITE : RESP;
            end
            WRITE: begin
                w_writeEn   = 1'b1;
                w_nextState = RESP;
            end
            RESP: begin
                if (w_rspFire) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Capture the instruction fields when the request is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= '0;
            r_addr    <= '0;
            r_wid     <= '0;
            r_uuid    <= '0;
            r_src     <= '0;
            r_srcZero <= 1'b0;
            r_rdZero  <= 1'b0;
        end else if (w_accept) begin
            r_op      <= req_op;
            r_addr    <= req_addr;
            r_wid     <= req_wid;
            r_uuid    <= req_uuid;
            r_src     <= req_src;
            r_srcZero <= req_src_zero;
            r_rdZero  <= req_rd_zero;
        end
    end

    // Latch the old CSR value in READ. It is zero when the read is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_old <= '0;
        end else if (r_state == READ) begin
            r_old <= w_needRead ? w_readData : '0;
        end
    end

    // Flag an attempted write to a read-only CSR. It is cleared by the next request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if ((r_state == READ) && w_needWrite && w_roAddr) begin
            r_err <= 1'b1;
        end
    end

    // Read-modify-write value. It is pure bitwise logic, and op 3 behaves as set.
    always_comb begin
        w_newVal = r_old | r_src;
        case (r_op)
            OP_RW:   w_newVal = r_src;
            OP_RC:   w_newVal = r_old & ~r_src;
            default: w_newVal = r_old | r_src;
        endcase
    end

    // Request fields to the CSR block are zero whenever their strobe is idle.
    assign csr_read_enable  = w_readEn;
    assign csr_read_uuid    = w_readEn ? r_uuid : '0;
    assign csr_read_wid     = w_readEn ? r_wid  : '0;
    assign csr_read_addr    = w_readEn ? r_addr : '0;

    assign csr_write_enable = w_writeEn;
    assign csr_write_uuid   = w_writeEn ? r_uuid   : '0;
    assign csr_write_wid    = w_writeEn ? r_wid    : '0;
    assign csr_write_addr   = w_writeEn ? r_addr   : '0;
    assign csr_write_data   = w_writeEn ? w_newVal : '0;

    // Response fields come straight from registers, so they hold steady under backpressure.
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = rsp_valid ? r_old  : '0;
    assign rsp_error = rsp_valid && r_err;
    assign rsp_uuid  = rsp_valid ? r_uuid : '0;
    assign rsp_wid   = rsp_valid ? r_wid  : '0;

endmodule

// File: tb/tb_vx_csr_requester.sv
// Testbench for vx_csr_requester. It runs a table of directed vectors, some
// hand-written reset and stall sequences, and randomized transactions. The
// random transactions are checked against a rule-level reference model.
module tb_vx_csr_requester;

    localparam int XLEN       = 32;
    localparam int NUM_WARPS  = 4;
    localparam int NW_WIDTH   = 2;
    localparam int UUID_WIDTH = 1;
    localparam int ADDR_BITS  = 12;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [1:0]            req_op = '0;
    logic [ADDR_BITS-1:0]  req_addr = '0;
    logic [NW_WIDTH-1:0]   req_wid = '0;
    logic [UUID_WIDTH-1:0] req_uuid = '0;
    logic [XLEN-1:0]       req_src = '0;
    logic                  req_src_zero = 1'b0;
    logic                  req_rd_zero = 1'b0;
    logic [NUM_WARPS-1:0]  fpu_pending = '0;
    logic                  csr_read_enable;
    logic [UUID_WIDTH-1:0] csr_read_uuid;
    logic [NW_WIDTH-1:0]   csr_read_wid;
    logic [ADDR_BITS-1:0]  csr_read_addr;
    logic [XLEN-1:0]       csr_read_data_ro = '0;
    logic [XLEN-1:0]       csr_read_data_rw = '0;
    logic                  csr_write_enable;
    logic [UUID_WIDTH-1:0] csr_write_uuid;
    logic [NW_WIDTH-1:0]   csr_write_wid;
    logic [ADDR_BITS-1:0]  csr_write_addr;
    logic [XLEN-1:0]       csr_write_data;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [XLEN-1:0]       rsp_data;
    logic                  rsp_error;
    logic [UUID_WIDTH-1:0] rsp_uuid;
    logic [NW_WIDTH-1:0]   rsp_wid;

    vx_csr_requester #(
        .XLEN(XLEN), .NUM_WARPS(NUM_WARPS), .NW_WIDTH(NW_WIDTH),
        .UUID_WIDTH(UUID_WIDTH), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wid(req_wid), .req_uuid(req_uuid),
        .req_src(req_src), .req_src_zero(req_src_zero), .req_rd_zero(req_rd_zero),
        .fpu_pending(fpu_pending),
        .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
        .csr_read_wid(csr_read_wid), .csr_read_addr(csr_read_addr),
        .csr_read_data_ro(csr_read_data_ro), .csr_read_data_rw(csr_read_data_rw),
        .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
        .csr_write_wid(csr_write_wid), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [1:0]  wid;
        logic        uuid;
        logic [31:0] src;
        logic        srcZero;
        logic        rdZero;
        logic [31:0] ro;
        logic [31:0] rw;
        int          hold;
        int          stall;
        int          expRd;
        int          expWr;
        logic [31:0] expWdata;
        int          expRsp;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          oRdCyc, oRdCnt, oWrCyc, oWrCnt, oRspCyc;
    logic [31:0] oWdata, oRdata;
    logic        oErr, oUuid, oIdOk, oBusyOk, oStable, oTimeout, oAfterReady, oAfterValid;
    logic [1:0]  oWid;

    // Compare one value and record the result
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one instruction, observe the whole transaction, stall the response and then release it
    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [1:0] wid,
                                 input logic uuid, input logic [31:0] src, input logic srcZero,
                                 input logic rdZero, input logic [31:0] ro, input logic [31:0] rw,
                                 input int hold, input int stall);
        int  n;
        bit  seen;
        oRdCyc = 0; oRdCnt = 0; oWrCyc = 0; oWrCnt = 0; oRspCyc = 0;
        oWdata = '0; oRdata = '0; oErr = 1'b0; oUuid = 1'b0; oWid = '0;
        oIdOk = 1'b1; oBusyOk = 1'b1; oStable = 1'b1; oTimeout = 1'b0;
        oAfterReady = 1'b0; oAfterValid = 1'b1;
        @(negedge clk);
        csr_read_data_ro = ro;
        csr_read_data_rw = rw;
        fpu_pending[wid] = (hold > 0);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wid = wid; req_uuid = uuid;
        req_src = src; req_src_zero = srcZero; req_rd_zero = rdZero;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 12'($urandom); req_wid = 2'($urandom);
        req_uuid = 1'($urandom); req_src = $urandom; req_src_zero = 1'($urandom);
        req_rd_zero = 1'($urandom);
        n = 1;
        seen = 0;
        while (!seen && n <= 40) begin
            if (req_ready !== 1'b0) oBusyOk = 1'b0;
            if (csr_read_enable === 1'b1) begin
                oRdCnt++;
                if (oRdCyc == 0) oRdCyc = n;
                if (csr_read_addr !== addr || csr_read_wid !== wid || csr_read_uuid !== uuid) oIdOk = 1'b0;
            end else if (csr_read_addr !== '0 || csr_read_wid !== '0 || csr_read_uuid !== '0) begin
                oIdOk = 1'b0;
            end
            if (csr_write_enable === 1'b1) begin
                oWrCnt++;
                if (oWrCyc == 0) oWrCyc = n;
                oWdata = csr_write_data;
                if (csr_write_addr !== addr || csr_write_wid !== wid || csr_write_uuid !== uuid) oIdOk = 1'b0;
            end else if (csr_write_addr !== '0 || csr_write_wid !== '0 || csr_write_uuid !== '0 ||
                         csr_write_data !== '0) begin
                oIdOk = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                seen = 1;
                oRspCyc = n;
                oRdata = rsp_data; oErr = rsp_error; oUuid = rsp_uuid; oWid = rsp_wid;
            end else begin
                if (hold > 0 && n == hold) fpu_pending[wid] = 1'b0;
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (w != int'(wid)) fpu_pending[w] = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                n++;
            end
        end
        fpu_pending[wid] = 1'b0;
        if (!seen) begin
            oTimeout = 1'b1;
        end else begin
            repeat (stall) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b1 || rsp_data !== oRdata || rsp_error !== oErr ||
                    rsp_uuid !== oUuid || rsp_wid !== oWid || req_ready !== 1'b0 ||
                    csr_read_enable !== 1'b0 || csr_write_enable !== 1'b0) oStable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            oAfterReady = req_ready;
            oAfterValid = rsp_valid;
        end
    endtask

    // Compare one observed transaction against its expected outcome
    task automatic checkTxn(input string tag, input int expRd, input int expWr, input logic [31:0] expWdata,
                            input int expRsp, input logic [31:0] expData, input logic expErr,
                            input logic uuid, input logic [1:0] wid);
        checkOutput({tag, ".timeout"}, 64'(oTimeout), 64'd0);
        checkOutput({tag, ".rdCount"}, 64'(oRdCnt), (expRd != 0) ? 64'd1 : 64'd0);
        if (expRd != 0) checkOutput({tag, ".rdCycle"}, 64'(oRdCyc), 64'(expRd));
        checkOutput({tag, ".wrCount"}, 64'(oWrCnt), (expWr != 0) ? 64'd1 : 64'd0);
        if (expWr != 0) begin
            checkOutput({tag, ".wrCycle"}, 64'(oWrCyc), 64'(expWr));
            checkOutput({tag, ".wrData"}, 64'(oWdata), 64'(expWdata));
        end
        checkOutput({tag, ".rspCycle"}, 64'(oRspCyc), 64'(expRsp));
        checkOutput({tag, ".rspData"}, 64'(oRdata), 64'(expData));
        checkOutput({tag, ".rspError"}, 64'(oErr), 64'(expErr));
        checkOutput({tag, ".rspIds"}, {62'd0, oUuid, 1'b0} | 64'(oWid) << 2, {62'd0, uuid, 1'b0} | 64'(wid) << 2);
        checkOutput({tag, ".strobeIds"}, 64'(oIdOk), 64'd1);
        checkOutput({tag, ".busyNotReady"}, 64'(oBusyOk), 64'd1);
        checkOutput({tag, ".rspStable"}, 64'(oStable), 64'd1);
        checkOutput({tag, ".readyAfter"}, {62'd0, oAfterValid, oAfterReady}, 64'd1);
    endtask

    vec_t vecs[13];

    initial begin
        logic [1:0]  op;
        logic [11:0] addr;
        logic [1:0]  wid;
        logic        uuid, srcZero, rdZero, needRead, needWrite, roAddr, fpAddr, doWrite;
        logic [31:0] src, ro, rw, oldVal, newVal;
        int          hold, stall, h, sel;
        logic [11:0] addrPool [8];

        //           op     addr     wid   uuid  src            sz    rz    ro            rw            h  s   rd wr wdata          rsp data           err
        vecs[0]  = '{2'd0, 12'h340, 2'd0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h12345678, 0, 0,  1, 2, 32'hDEADBEEF, 3, 32'h12345678, 1'b0};
        vecs[1]  = '{2'd1, 12'h340, 2'd1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        32'hA5,       0, 0,  1, 0, 32'h0,        2, 32'hA5,       1'b0};
        vecs[2]  = '{2'd2, 12'h340, 2'd3, 1'b0, 32'h0F,       1'b0, 1'b0, 32'h0,        32'hFF,       0, 0,  1, 2, 32'hF0,       3, 32'hFF,       1'b0};
        vecs[3]  = '{2'd0, 12'h340, 2'd2, 1'b1, 32'h55,       1'b0, 1'b1, 32'h0,        32'h77,       0, 0,  0, 2, 32'h55,       3, 32'h0,        1'b0};
        vecs[4]  = '{2'd0, 12'hF14, 2'd0, 1'b0, 32'h1,        1'b0, 1'b0, 32'h7,        32'h0,        0, 0,  1, 0, 32'h0,        2, 32'h7,        1'b1};
        vecs[5]  = '{2'd1, 12'hF14, 2'd0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h7,        32'h0,        0, 0,  1, 0, 32'h0,        2, 32'h7,        1'b0};
        vecs[6]  = '{2'd3, 12'h340, 2'd1, 1'b0, 32'h0F00,     1'b0, 1'b0, 32'hF0,       32'h0F,       0, 0,  1, 2, 32'h0FFF,     3, 32'hFF,       1'b0};
        vecs[7]  = '{2'd1, 12'hC00, 2'd2, 1'b0, 32'h10,       1'b0, 1'b0, 32'h3,        32'h0,        0, 0,  1, 0, 32'h0,        2, 32'h3,        1'b1};
        vecs[8]  = '{2'd2, 12'h340, 2'd3, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        32'hF0F0,     0, 0,  1, 0, 32'h0,        2, 32'hF0F0,     1'b0};
        vecs[9]  = '{2'd0, 12'hC01, 2'd1, 1'b0, 32'hAA,       1'b0, 1'b1, 32'h9,        32'h9,        0, 0,  0, 0, 32'h0,        2, 32'h0,        1'b1};
        vecs[10] = '{2'd0, 12'h003, 2'd2, 1'b1, 32'h1F,       1'b0, 1'b0, 32'h0,        32'h3,        5, 0,  6, 7, 32'h1F,       8, 32'h3,        1'b0};
        vecs[11] = '{2'd1, 12'h340, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h5A,       3, 10, 1, 0, 32'h0,        2, 32'h5A,       1'b0};
        vecs[12] = '{2'd2, 12'h002, 2'd3, 1'b1, 32'hF0,       1'b0, 1'b0, 32'h0,        32'hFF,       2, 0,  3, 4, 32'h0F,       5, 32'hFF,       1'b0};

        addrPool[0] = 12'h001; addrPool[1] = 12'h002; addrPool[2] = 12'h003; addrPool[3] = 12'h340;
        addrPool[4] = 12'h300; addrPool[5] = 12'hF14; addrPool[6] = 12'hC00; addrPool[7] = 12'h7FF;

        // reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.reqReady", 64'(req_ready), 64'd0);
        checkOutput("reset.strobes", {62'd0, csr_read_enable, csr_write_enable}, 64'd0);
        checkOutput("reset.rspValid", {62'd0, rsp_valid, rsp_error}, 64'd0);
        checkOutput("reset.data", 64'(rsp_data) | 64'(csr_write_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset.readyAfterRelease", 64'(req_ready), 64'd1);

        // directed table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wid, vecs[i].uuid, vecs[i].src,
                          vecs[i].srcZero, vecs[i].rdZero, vecs[i].ro, vecs[i].rw,
                          vecs[i].hold, vecs[i].stall);
            checkTxn($sformatf("vec%0d", i), vecs[i].expRd, vecs[i].expWr, vecs[i].expWdata,
                     vecs[i].expRsp, vecs[i].expData, vecs[i].expErr, vecs[i].uuid, vecs[i].wid);
        end

        // randomized transactions against the rule-level model
        for (int t = 0; t < 60; t++) begin
            op      = 2'($urandom);
            sel     = $urandom_range(0, 8);
            addr    = (sel == 8) ? 12'($urandom) : addrPool[sel];
            wid     = 2'($urandom);
            uuid    = 1'($urandom);
            srcZero = ($urandom_range(0, 3) == 0);
            src     = srcZero ? 32'h0 : $urandom;
            rdZero  = ($urandom_range(0, 3) == 0);
            ro      = $urandom;
            rw      = $urandom;
            hold    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            stall   = $urandom_range(0, 3);

            needWrite = (op == 2'd0) || !srcZero;
            needRead  = !((op == 2'd0) && rdZero);
            roAddr    = (addr[11:10] == 2'b11);
            fpAddr    = (addr >= 12'h001) && (addr <= 12'h003);
            h         = fpAddr ? hold : 0;
            oldVal    = needRead ? (ro | rw) : 32'h0;
            newVal    = (op == 2'd0) ? src : (op == 2'd2) ? (oldVal & ~src) : (oldVal | src);
            doWrite   = needWrite && !roAddr;

            applyStimulus(op, addr, wid, uuid, src, srcZero, rdZero, ro, rw, hold, stall);
            checkTxn($sformatf("rnd%0d", t), needRead ? 1 + h : 0, doWrite ? 2 + h : 0, newVal,
                     (doWrite ? 3 : 2) + h, oldVal, needWrite && roAddr, uuid, wid);
        end

        // reset pulsed in the middle of a write
        @(negedge clk);
        csr_read_data_ro = 32'h0; csr_read_data_rw = 32'h1111;
        req_valid = 1'b1; req_op = 2'd0; req_addr = 12'h340; req_wid = 2'd1; req_uuid = 1'b1;
        req_src = 32'hCAFEF00D; req_src_zero = 1'b0; req_rd_zero = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstMid.writeActive", 64'(csr_write_enable), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstMid.strobeDrop", {62'd0, csr_write_enable, csr_read_enable}, 64'd0);
        checkOutput("rstMid.writeFields", 64'(csr_write_data) | 64'(csr_write_addr) | 64'(csr_write_wid), 64'd0);
        checkOutput("rstMid.rsp", {61'd0, rsp_valid, rsp_error, req_ready}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        oStable = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (csr_write_enable !== 1'b0 || csr_read_enable !== 1'b0 || rsp_valid !== 1'b0) oStable = 1'b0;
        end
        checkOutput("rstMid.noPartialWrite", 64'(oStable), 64'd1);
        checkOutput("rstMid.readyAgain", 64'(req_ready), 64'd1);

        // normal operation after the reset
        applyStimulus(2'd0, 12'h340, 2'd3, 1'b0, 32'h600DF00D, 1'b0, 1'b0, 32'h0, 32'h00C0FFEE, 0, 2);
        checkTxn("postReset", 1, 2, 32'h600DF00D, 3, 32'h00C0FFEE, 1'b0, 1'b0, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
